// File: rtl/uart_tx_fifo.sv
// 8N1 RS232 transmitter fed by a small byte FIFO over a valid/ready handshake.
// Frames are sent LSB first and leave back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       TX,
  output logic       busy
);

  localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CW         = $clog2(BIT_PERIOD) + 1;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int NW         = AW + 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] CNT_ONE   = NW'(1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Handshake: a byte is taken on any posedge where in_valid && in_ready.
  // in_ready depends only on the registered count, never on in_valid.

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [NW-1:0]   count;
  logic [CW-1:0]   cycle_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            tx_q;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            bit_end;
  logic [7:0]      head;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != CNT_FULL);
  assign push       = in_valid && in_ready;
  assign bit_end    = (cycle_cnt == CYC_LAST);
  assign head       = mem[rd_ptr];

  // A pop loads the next frame: from IDLE at once, or at the stop-bit end.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == STOP && bit_end)
        pop = 1'b1;
    end
  end

  assign TX   = tx_q;
  assign busy = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // TX is updated on the same edge as the state change so the line level
  // always matches the state being entered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift     <= head;
            cycle_cnt <= '0;
            tx_q      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            tx_q      <= shift[0];
            state     <= DATA;
          end else begin
            cycle_cnt <= cycle_cnt + CYC_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CYC_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (pop) begin
              shift <= head;
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              tx_q  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CYC_ONE;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
